psram_spi_responder: RTL

//  Target-side SPI PSRAM responder: decodes the serial command stream driven by our PSRAM

---
 rtl/psram_pkg.sv | 41 ++++
 rtl/psram_resp_mem.sv | 22 ++
 rtl/psram_spi_responder.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/psram_pkg.sv
// Shared opcodes, FSM state encoding and Read-ID byte selection for the PSRAM SPI responder.
package psram_pkg;

  localparam logic [7:0] CMD_RSTEN = 8'h66;
  localparam logic [7:0] CMD_RST   = 8'h99;
  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam logic [7:0] CMD_FREAD = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RDATA,
    ST_WDATA,
    ST_IDOUT,
    ST_IGNORE
  } psram_state_e;

  // Read-ID sequence: MFID, KGD, then the six EID bytes MSB first.
  function automatic logic [7:0] id_byte(input logic [2:0]  idx,
                                         input logic [7:0]  mfid,
                                         input logic [7:0]  kgd,
                                         input logic [47:0] eid);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mfid;
      3'd1:    b = kgd;
      3'd2:    b = eid[47:40];
      3'd3:    b = eid[39:32];
      3'd4:    b = eid[31:24];
      3'd5:    b = eid[23:16];
      3'd6:    b = eid[15:8];
      default: b = eid[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// Single-port byte-wide RAM backing the responder; registered read, write has priority.
module psram_resp_mem #(
  parameter int AW = 10
) (
  input  logic          sys_clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge sys_clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata       <= mem_q[addr];
    end
  end

endmodule

// File: rtl/psram_spi_responder.sv
// SPI PSRAM target: oversamples ce_n/sclk/si in sys_clk, decodes commands, serves the RAM.
// Define PSRAM_FAST_READ_EN to accept Fast Read (0x0B) with 8 dummy clocks.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | ce_n high, waiting for a frame
// ST_CMD    | shifting the opcode byte (stays here after 0x66 for a same-frame 0x99)
// ST_ADDR   | shifting the 24-bit address
// ST_DUMMY  | fast-read dummy byte, output disabled
// ST_RDATA  | streaming array bytes out on so
// ST_WDATA  | writing each completed byte into the array
// ST_IDOUT  | streaming the ID sequence out on so
// ST_IGNORE | swallowing clocks until ce_n rises
module psram_spi_responder
  import psram_pkg::*;
#(
  parameter int          MEM_AW = 10,
  parameter logic [7:0]  MFID   = 8'h0D,
  parameter logic [7:0]  KGD    = 8'h5D,
  parameter logic [47:0] EID    = 48'h0
) (
  input  logic sys_clk,
  input  logic sys_reset_n,
  input  logic ce_n,
  input  logic sclk,
  input  logic si,
  output logic so,
  output logic so_oe,
  output logic rst_pulse,
  output logic cmd_err
);

  logic [1:0] ce_sync, sclk_sync, si_sync;
  logic       sclk_d;
  logic       ce_hi, sclk_rise, sclk_fall, si_bit;

  psram_state_e state, state_nxt;

  logic [2:0]        bit_cnt;
  logic [6:0]        shifter;
  logic [7:0]        byte_in;
  logic              byte_done;
  logic [7:0]        cmd_q;
  logic [23:0]       addr;
  logic [23:0]       addr_full;
  logic [23:0]       addr_step;
  logic [MEM_AW-1:0] mem_ptr_inc;
  logic [1:0]        addr_bcnt;
  logic [2:0]        id_idx;
  logic [7:0]        so_sh;
  logic              so_r;
  logic [7:0]        out_byte;
  logic              rst_armed;

  logic              rst_pulse_nxt, cmd_err_nxt, arm_set, arm_clr;
  logic              cmd_ld, addr_inc, id_clr;
  logic              mem_en, mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        rd_data;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      ce_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      si_sync   <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      ce_sync   <= {ce_sync[0], ce_n};
      sclk_sync <= {sclk_sync[0], sclk};
      si_sync   <= {si_sync[0], si};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign ce_hi     = ce_sync[1];
  assign sclk_rise = sclk_sync[1] & ~sclk_d;
  assign sclk_fall = ~sclk_sync[1] & sclk_d;
  assign si_bit    = si_sync[1];

  assign byte_in     = {shifter, si_bit};
  assign byte_done   = sclk_rise && (bit_cnt == 3'd7);
  assign addr_full   = {addr[22:0], si_bit};
  assign mem_ptr_inc = addr[MEM_AW-1:0] + MEM_AW'(1);
  assign addr_step   = {addr[23:MEM_AW], mem_ptr_inc};
  assign out_byte    = (state == ST_IDOUT) ? id_byte(id_idx, MFID, KGD, EID) : rd_data;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    rst_pulse_nxt = 1'b0;
    cmd_err_nxt   = 1'b0;
    arm_set       = 1'b0;
    arm_clr       = 1'b0;
    cmd_ld        = 1'b0;
    addr_inc      = 1'b0;
    id_clr        = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = addr[MEM_AW-1:0];
    case (state)
      ST_IDLE: if (!ce_hi) state_nxt = ST_CMD;
      ST_CMD: if (byte_done) begin
        case (byte_in)
          CMD_RSTEN: arm_set = 1'b1;
          CMD_RST: begin
            rst_pulse_nxt = rst_armed;
            arm_clr       = 1'b1;
            state_nxt     = ST_IGNORE;
          end
          CMD_RDID, CMD_READ, CMD_WRITE: begin
            arm_clr   = 1'b1;
            cmd_ld    = 1'b1;
            state_nxt = ST_ADDR;
          end
`ifdef PSRAM_FAST_READ_EN
          CMD_FREAD: begin
            arm_clr   = 1'b1;
            cmd_ld    = 1'b1;
            state_nxt = ST_ADDR;
          end
`endif
          default: begin
            cmd_err_nxt = 1'b1;
            arm_clr     = 1'b1;
            state_nxt   = ST_IGNORE;
          end
        endcase
      end
      ST_ADDR: if (byte_done && addr_bcnt == 2'd2) begin
        if (cmd_q == CMD_RDID) begin
          state_nxt = ST_IDOUT;
          id_clr    = 1'b1;
        end else if (cmd_q == CMD_WRITE) begin
          state_nxt = ST_WDATA;
`ifdef PSRAM_FAST_READ_EN
        end else if (cmd_q == CMD_FREAD) begin
          state_nxt = ST_DUMMY;
`endif
        end else begin
          // First read byte must be ready before the next falling edge.
          state_nxt = ST_RDATA;
          mem_en    = 1'b1;
          mem_addr  = addr_full[MEM_AW-1:0];
        end
      end
      ST_DUMMY: if (byte_done) begin
        state_nxt = ST_RDATA;
        mem_en    = 1'b1;
      end
      ST_RDATA: if (sclk_rise && bit_cnt == 3'd3) begin
        mem_en   = 1'b1;
        mem_addr = mem_ptr_inc;
        addr_inc = 1'b1;
      end
      // A byte completing alongside ce_n rising is still committed.
      ST_WDATA: if (byte_done) begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        addr_inc = 1'b1;
      end
      ST_IDOUT, ST_IGNORE: ;
      default: state_nxt = ST_IDLE;
    endcase
    if (ce_hi) state_nxt = ST_IDLE;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      bit_cnt   <= 3'd0;
      shifter   <= 7'd0;
      cmd_q     <= 8'd0;
      addr      <= 24'd0;
      addr_bcnt <= 2'd0;
      id_idx    <= 3'd0;
      so_sh     <= 8'd0;
      so_r      <= 1'b0;
      rst_armed <= 1'b0;
      rst_pulse <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      if (ce_hi)          bit_cnt <= 3'd0;
      else if (sclk_rise) bit_cnt <= bit_cnt + 3'd1;
      if (sclk_rise) shifter <= byte_in[6:0];

      if (cmd_ld) begin
        cmd_q     <= byte_in;
        addr_bcnt <= 2'd0;
      end

      if (state == ST_ADDR && sclk_rise) begin
        addr <= addr_full;
        if (bit_cnt == 3'd7) addr_bcnt <= addr_bcnt + 2'd1;
      end else if (addr_inc) begin
        addr <= addr_step;
      end

      if (arm_set)      rst_armed <= 1'b1;
      else if (arm_clr) rst_armed <= 1'b0;
      rst_pulse <= rst_pulse_nxt;
      cmd_err   <= cmd_err_nxt;

      if (id_clr) id_idx <= 3'd0;

      if ((state == ST_RDATA || state == ST_IDOUT) && !ce_hi) begin
        if (sclk_fall) begin
          if (bit_cnt == 3'd0) begin
            {so_r, so_sh} <= {out_byte, 1'b0};
            if (state == ST_IDOUT) id_idx <= id_idx + 3'd1;
          end else begin
            {so_r, so_sh} <= {so_sh, 1'b0};
          end
        end
      end else begin
        so_r  <= 1'b0;
        so_sh <= 8'd0;
      end
    end
  end

  assign so_oe = (state == ST_RDATA || state == ST_IDOUT) && !ce_hi;
  assign so    = so_r & so_oe;

  psram_resp_mem #(.AW(MEM_AW)) u_mem (
    .sys_clk (sys_clk),
    .en      (mem_en),
    .we      (mem_we),
    .addr    (mem_addr),
    .wdata   (byte_in),
    .rdata   (rd_data)
  );

endmodule
